// File: rtl/fp_dump_pkg.sv
// Shared types and IEEE754 single-precision field positions for the FP register dump reader.
package fp_dump_pkg;

  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int QNAN_BIT = 22;

  typedef enum logic [2:0] {
    FP_ZERO      = 3'd0,
    FP_SUBNORMAL = 3'd1,
    FP_NORMAL    = 3'd2,
    FP_INF       = 3'd3,
    FP_QNAN      = 3'd4,
    FP_SNAN      = 3'd5
  } fp_class_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_t;

endpackage

// File: rtl/fp_regfile_dump_reader_if.sv
// Register-file read port plus the classified output stream of the dump reader.
interface fp_regfile_dump_reader_if
  import fp_dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);
  logic              rf_ren;
  logic [IDX_W-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_sign;
  fp_class_t         out_class;
  logic              out_last;

  modport master (
    output rf_ren, rf_raddr,
    input  rf_rdata,
    output out_valid, out_idx, out_data, out_sign, out_class, out_last,
    input  out_ready
  );

  modport slave (
    input  rf_ren, rf_raddr,
    output rf_rdata,
    input  out_valid, out_idx, out_data, out_sign, out_class, out_last,
    output out_ready
  );
endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE754 single classifier: sign bit and zero/subnormal/normal/inf/qnan/snan.
module fp_classify
  import fp_dump_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              sign_o,
  output fp_class_t         class_o
);

  logic [EXP_MSB-EXP_LSB:0] exp_w;
  logic [MAN_MSB:0]         man_w;

  assign exp_w  = data_i[EXP_MSB:EXP_LSB];
  assign man_w  = data_i[MAN_MSB:0];
  assign sign_o = data_i[DATA_W-1];

  always_comb begin
    class_o = FP_NORMAL;
    if (exp_w == '0) begin
      class_o = (man_w == '0) ? FP_ZERO : FP_SUBNORMAL;
    end else if (exp_w == '1) begin
      if (man_w == '0)          class_o = FP_INF;
      else if (man_w[QNAN_BIT]) class_o = FP_QNAN;
      else                      class_o = FP_SNAN;
    end
  end

endmodule

// File: rtl/fp_regfile_dump_reader.sv
// Walks an inclusive (wrapping) register range, reading one FP register per word
// and streaming it out with its index, sign, class and last flag.
module fp_regfile_dump_reader
  import fp_dump_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [IDX_W-1:0] last_idx,
  output logic             busy,
  output logic             done,
  fp_regfile_dump_reader_if.master bus
);

  dump_state_t       state_q;
  logic [IDX_W-1:0]  idx_q, last_q, raddr_q, out_idx_q;
  logic              rf_ren_q, out_valid_q, out_sign_q, out_last_q, busy_q, done_q;
  logic [DATA_W-1:0] out_data_q;
  fp_class_t         out_class_q;

  logic              sign_d;
  fp_class_t         class_d;
  logic [IDX_W-1:0]  idx_d;

  // Index width equals log2(NUM_REGS), so the increment wraps modulo NUM_REGS.
  assign idx_d = idx_q + 1'b1;

  fp_classify #(.DATA_W(DATA_W)) u_classify (
    .data_i  (bus.rf_rdata),
    .sign_o  (sign_d),
    .class_o (class_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      raddr_q     <= '0;
      rf_ren_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_sign_q  <= 1'b0;
      out_class_q <= FP_ZERO;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rf_ren_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          idx_q    <= first_idx;
          last_q   <= last_idx;
          raddr_q  <= first_idx;
          rf_ren_q <= 1'b1;
          busy_q   <= 1'b1;
          state_q  <= ST_READ;
        end
        ST_READ: state_q <= ST_CAPTURE;
        // Read data arrives this cycle; freeze the whole payload for SEND.
        ST_CAPTURE: begin
          out_data_q  <= bus.rf_rdata;
          out_idx_q   <= idx_q;
          out_sign_q  <= sign_d;
          out_class_q <= class_d;
          out_last_q  <= (idx_q == last_q);
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          if (out_last_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q    <= idx_d;
            raddr_q  <= idx_d;
            rf_ren_q <= 1'b1;
            state_q  <= ST_READ;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rf_ren    = rf_ren_q;
  assign bus.rf_raddr  = raddr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_class = out_class_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_fp_regfile_dump_reader.sv
// Directed bench for the FP register dump reader with a one-cycle-latency register file model.
module tb_fp_regfile_dump_reader;

  localparam logic [2:0] C_ZERO = 3'd0, C_SUB = 3'd1, C_NORM = 3'd2,
                         C_INF  = 3'd3, C_QNAN = 3'd4, C_SNAN = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] first_idx, last_idx;
  logic       busy, done;
  logic [31:0] rf [32];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int dc_save;

  fp_regfile_dump_reader_if #(.DATA_W(32), .IDX_W(5)) bus ();

  fp_regfile_dump_reader #(.NUM_REGS(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Register file: data is only meaningful the cycle after a read enable.
  always @(posedge clk) bus.rf_rdata <= bus.rf_ren ? rf[bus.rf_raddr] : 32'hDEAD_BEEF;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic expect_word(input string tag, input logic [4:0] idx, input logic [31:0] data,
                             input logic [2:0] cls, input logic sgn, input logic lst);
    wait_valid(tag);
    chk({tag, "_idx"},   {27'd0, bus.out_idx},   {27'd0, idx});
    chk({tag, "_data"},  bus.out_data,           data);
    chk({tag, "_class"}, {29'd0, bus.out_class}, {29'd0, cls});
    chk({tag, "_sign"},  {31'd0, bus.out_sign},  {31'd0, sgn});
    chk({tag, "_last"},  {31'd0, bus.out_last},  {31'd0, lst});
    tick();
  endtask

  task automatic expect_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    tick();
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic kick(input logic [4:0] f, input logic [4:0] l);
    start = 1'b1;
    first_idx = f;
    last_idx = l;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h3F80_0000 + (i << 16);
    rf[0]  = 32'h3F80_0000;
    rf[1]  = 32'h4048_F5C3;
    rf[2]  = 32'h402D_F854;
    rf[3]  = 32'h4040_0000;
    rf[4]  = 32'h4080_0000;
    rf[5]  = 32'h40A0_0000;
    rf[6]  = 32'h40C0_0000;
    rf[14] = 32'h7F80_0000;
    rf[15] = 32'h7FC0_0000;
    rf[16] = 32'h7FA0_0000;
    rf[17] = 32'h8000_0000;
    rf[18] = 32'h0000_0001;
    rf[30] = 32'hC000_0000;
    rf[31] = 32'h0040_0000;

    reset = 1'b1;
    start = 1'b0;
    first_idx = '0;
    last_idx = '0;
    bus.out_ready = 1'b1;
    tick();
    chk("rst_busy",   {31'd0, busy},          32'd0);
    chk("rst_done",   {31'd0, done},          32'd0);
    chk("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("rst_last",   {31'd0, bus.out_last},  32'd0);
    chk("rst_ren",    {31'd0, bus.rf_ren},    32'd0);
    chk("rst_raddr",  {27'd0, bus.rf_raddr},  32'd0);
    chk("rst_idx",    {27'd0, bus.out_idx},   32'd0);
    chk("rst_data",   bus.out_data,           32'd0);
    chk("rst_sign",   {31'd0, bus.out_sign},  32'd0);
    chk("rst_class",  {29'd0, bus.out_class}, 32'd0);
    reset = 1'b0;
    tick();

    // Two normal words, cycle-exact latency.
    kick(5'd1, 5'd2);
    chk("t1_ren",    {31'd0, bus.rf_ren},    32'd1);
    chk("t1_raddr",  {27'd0, bus.rf_raddr},  32'd1);
    chk("t1_busy",   {31'd0, busy},          32'd1);
    chk("t1_v_t1",   {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("t1_ren_t2", {31'd0, bus.rf_ren},    32'd0);
    chk("t1_v_t2",   {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("t1_v_t3",   {31'd0, bus.out_valid}, 32'd1);
    expect_word("t1_w0", 5'd1, 32'h4048_F5C3, C_NORM, 1'b0, 1'b0);
    chk("t1_ren2",   {31'd0, bus.rf_ren},    32'd1);
    chk("t1_raddr2", {27'd0, bus.rf_raddr},  32'd2);
    chk("t1_v_t4",   {31'd0, bus.out_valid}, 32'd0);
    tick();
    tick();
    chk("t1_v_t6",   {31'd0, bus.out_valid}, 32'd1);
    expect_word("t1_w1", 5'd2, 32'h402D_F854, C_NORM, 1'b0, 1'b1);
    chk("t1_done_t7", {31'd0, done}, 32'd1);
    expect_done("t1");
    chk("t1_done_cnt", done_cnt, 32'd1);

    // Special values.
    kick(5'd14, 5'd18);
    expect_word("t2_inf",  5'd14, 32'h7F80_0000, C_INF,  1'b0, 1'b0);
    expect_word("t2_qnan", 5'd15, 32'h7FC0_0000, C_QNAN, 1'b0, 1'b0);
    expect_word("t2_snan", 5'd16, 32'h7FA0_0000, C_SNAN, 1'b0, 1'b0);
    expect_word("t2_nzro", 5'd17, 32'h8000_0000, C_ZERO, 1'b1, 1'b0);
    expect_word("t2_sub",  5'd18, 32'h0000_0001, C_SUB,  1'b0, 1'b1);
    expect_done("t2");

    // Range wrapping through index 0.
    kick(5'd30, 5'd1);
    expect_word("t3_30", 5'd30, 32'hC000_0000, C_NORM, 1'b1, 1'b0);
    expect_word("t3_31", 5'd31, 32'h0040_0000, C_SUB,  1'b0, 1'b0);
    expect_word("t3_0",  5'd0,  32'h3F80_0000, C_NORM, 1'b0, 1'b0);
    expect_word("t3_1",  5'd1,  32'h4048_F5C3, C_NORM, 1'b0, 1'b1);
    expect_done("t3");

    // Backpressure holds the payload.
    bus.out_ready = 1'b0;
    kick(5'd1, 5'd1);
    wait_valid("t4");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t4_hold_data",  bus.out_data,           32'h4048_F5C3);
      chk("t4_hold_idx",   {27'd0, bus.out_idx},   32'd1);
      chk("t4_hold_ren",   {31'd0, bus.rf_ren},    32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t4_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    expect_done("t4");

    // Reset in the middle of a four-word dump, then a fresh single-word dump.
    kick(5'd3, 5'd6);
    expect_word("t5_w0", 5'd3, 32'h4040_0000, C_NORM, 1'b0, 1'b0);
    wait_valid("t5_w1");
    chk("t5_w1_idx", {27'd0, bus.out_idx}, 32'd4);
    dc_save = done_cnt;
    reset = 1'b1;
    #1;
    chk("t5_async_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t5_async_busy",  {31'd0, busy},          32'd0);
    chk("t5_async_ren",   {31'd0, bus.rf_ren},    32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t5_no_done", done_cnt, dc_save);
    kick(5'd0, 5'd0);
    chk("t5_ren",   {31'd0, bus.rf_ren},   32'd1);
    chk("t5_raddr", {27'd0, bus.rf_raddr}, 32'd0);
    tick();
    chk("t5_v_t2",  {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("t5_v_t3",  {31'd0, bus.out_valid}, 32'd1);
    expect_word("t5_r0", 5'd0, 32'h3F80_0000, C_NORM, 1'b0, 1'b1);
    expect_done("t5");

    // Start while busy is ignored.
    kick(5'd1, 5'd2);
    start = 1'b1;
    first_idx = 5'd14;
    last_idx = 5'd18;
    expect_word("t6_w0", 5'd1, 32'h4048_F5C3, C_NORM, 1'b0, 1'b0);
    start = 1'b0;
    expect_word("t6_w1", 5'd2, 32'h402D_F854, C_NORM, 1'b0, 1'b1);
    expect_done("t6");
    tick();
    tick();
    chk("t6_idle_busy", {31'd0, busy},       32'd0);
    chk("t6_idle_ren",  {31'd0, bus.rf_ren}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
